// File: rtl/sprite_row_renderer.sv
// sprite_row_renderer: walks one bitmap sprite per frame. On each scanline it
// fetches one row from an external combinational sprite ROM and shifts that row
// out MSB first as a 1-bit pixel stream on gfx.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-low reset
//   vstart       1-cycle strobe, sprite top reached this frame
//   load         1-cycle strobe, fetch the next row (during hblank)
//   hstart       1-cycle strobe, sprite left edge reached
//   rom_addr     registered row address to the sprite ROM
//   rom_bits     ROM data, combinationally valid for rom_addr
//   gfx          registered pixel, 1 = sprite pixel lit
//   in_progress  high while a sprite is active in this frame
//
// Optional feature: define SPRITE_HMIRROR_EN to draw each row twice as wide.
// The right half is the left half mirrored, which gives a symmetric sprite
// 2*WIDTH pixels wide.
//
// Timing: the strobes are registered once on entry, so the fetch and draw
// latencies are fixed and independent of the upstream compare logic.
//   hstart sampled at edge N -> pixel 0 on gfx after edge N+2.
//   load   sampled at edge N -> rom_addr after N+2, row captured at N+3.
//   Because of that, hstart is accepted from edge N+3 onward.
module sprite_row_renderer #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 16,
  localparam int AW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vstart,
  input  logic             load,
  input  logic             hstart,
  output logic [AW-1:0]    rom_addr,
  input  logic [WIDTH-1:0] rom_bits,
  output logic             gfx,
  output logic             in_progress
);

  // Number of pixels drawn per row.
`ifdef SPRITE_HMIRROR_EN
  localparam int DLEN = 2 * WIDTH;
`else
  localparam int DLEN = WIDTH;
`endif
  localparam int XW = (DLEN > 1) ? $clog2(DLEN) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] WAIT_VSTART = 3'd0;
  localparam logic [2:0] WAIT_LOAD   = 3'd1;
  localparam logic [2:0] LOAD_SETUP  = 3'd2;
  localparam logic [2:0] LOAD_FETCH  = 3'd3;
  localparam logic [2:0] WAIT_HSTART = 3'd4;
  localparam logic [2:0] DRAW        = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [AW-1:0]    ycount;
  logic [XW-1:0]    xcount;
  logic [WIDTH-1:0] row;
  logic             vstart_q;
  logic             load_q;
  logic             hstart_q;
  logic             x_last;
  logic             y_last;
  logic [IW-1:0]    pix_idx;
  logic             pix;

  assign x_last = (xcount == XW'(DLEN - 1));
  assign y_last = (ycount == AW'(HEIGHT - 1));

  // Map the draw position to a bit of the fetched row. The left half is
  // drawn MSB first. In the mirrored build, the right half walks the same
  // row LSB first.
  always_comb begin
    pix_idx = '0;
`ifdef SPRITE_HMIRROR_EN
    if (xcount >= XW'(WIDTH)) begin
      pix_idx = IW'(xcount - XW'(WIDTH));
    end else begin
      pix_idx = IW'(XW'(WIDTH - 1) - xcount);
    end
`else
    pix_idx = IW'(XW'(WIDTH - 1) - xcount);
`endif
  end

  assign pix = row[pix_idx];

  // The state machine only looks at the registered strobes. A strobe that
  // arrives while the state machine is in any other state is simply dropped.
  // For example, a load that comes together with vstart is consumed while
  // the state machine is still in WAIT_VSTART.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_VSTART: if (vstart_q) state_nxt = WAIT_LOAD;
      WAIT_LOAD:   if (load_q)   state_nxt = LOAD_SETUP;
      LOAD_SETUP:                state_nxt = LOAD_FETCH;
      LOAD_FETCH:                state_nxt = WAIT_HSTART;
      WAIT_HSTART: if (hstart_q) state_nxt = DRAW;
      DRAW: begin
        if (x_last) begin
          state_nxt = y_last ? WAIT_VSTART : WAIT_LOAD;
        end
      end
      default:                   state_nxt = WAIT_VSTART;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_VSTART;
      in_progress <= 1'b0;
      rom_addr    <= '0;
      gfx         <= 1'b0;
      ycount      <= '0;
      xcount      <= '0;
      row         <= '0;
      vstart_q    <= 1'b0;
      load_q      <= 1'b0;
      hstart_q    <= 1'b0;
    end else begin
      vstart_q    <= vstart;
      load_q      <= load;
      hstart_q    <= hstart;
      state       <= state_nxt;
      // in_progress is registered together with state, so it never
      // disagrees with state for a cycle.
      in_progress <= (state_nxt != WAIT_VSTART);
      gfx         <= 1'b0;
      case (state)
        WAIT_VSTART: begin
          ycount <= '0;
        end
        WAIT_LOAD: begin
          xcount <= '0;
        end
        LOAD_SETUP: begin
          rom_addr <= ycount;
        end
        LOAD_FETCH: begin
          row <= rom_bits;
        end
        DRAW: begin
          gfx <= pix;
          // Both counters saturate at their last value instead of wrapping.
          // WAIT_LOAD and WAIT_VSTART clear them before they are used again.
          if (!x_last) begin
            xcount <= xcount + XW'(1);
          end else if (!y_last) begin
            ycount <= ycount + AW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
